// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Owns the fetch PC and keeps at most one instruction-memory read in flight.
// Redirects from execute take priority over stall and consumption. The fetched
// instruction, its PC and PC+4 are presented to the fetch/decode register with
// a valid flag.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rstn         synchronous active-low reset
//   i_stallF       hold the presented instruction (only matters while valid)
//   i_redirect     taken branch/jump pulse from execute
//   i_redirect_pc  redirect target; bits [1:0] are forced to zero
//   o_imem_req     read request valid
//   o_imem_addr    read address (current PC)
//   i_imem_ready   memory accepts the request this cycle
//   i_imem_rvalid  read data valid, one cycle per accepted request
//   i_imem_rdata   instruction word
//   o_instr        fetched instruction
//   o_pc           PC of o_instr
//   o_pc_plus4     o_pc + 4 (wrapping)
//   o_instr_valid  o_instr/o_pc/o_pc_plus4 describe a live instruction
module fetch_unit #(
   parameter int unsigned            DATA_WIDTH  = 64,
   parameter int unsigned            INSTR_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]  RESET_PC    = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_stallF,
   input  logic                   i_redirect,
   input  logic [DATA_WIDTH-1:0]  i_redirect_pc,
   output logic                   o_imem_req,
   output logic [DATA_WIDTH-1:0]  o_imem_addr,
   input  logic                   i_imem_ready,
   input  logic                   i_imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [DATA_WIDTH-1:0]  o_pc,
   output logic [DATA_WIDTH-1:0]  o_pc_plus4,
   output logic                   o_instr_valid
);

   typedef enum logic [1:0] {
      StReq   = 2'd0,  // request outstanding on the bus (req high)
      StWait  = 2'd1,  // request accepted, waiting for rvalid
      StValid = 2'd2,  // instruction held for decode
      StDrain = 2'd3   // redirected while a response is in flight; discard it
   } state_e;

   state_e                 r_state;
   logic [DATA_WIDTH-1:0]  r_pc;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic                   r_valid;

   logic                   w_accept;
   logic [DATA_WIDTH-1:0]  w_pc_plus4;
   logic [DATA_WIDTH-1:0]  w_redirect_pc;

   // Request is suppressed combinationally during reset so nothing is issued
   // before the state register has been initialised.
   assign o_imem_req    = (r_state == StReq) && i_rstn;
   assign o_imem_addr   = r_pc;
   assign w_accept      = o_imem_req && i_imem_ready;
   assign w_pc_plus4    = r_pc + DATA_WIDTH'(4);
   assign w_redirect_pc = i_redirect_pc & ~DATA_WIDTH'(3);

   assign o_pc          = r_pc;
   assign o_pc_plus4    = w_pc_plus4;
   assign o_instr       = r_instr;
   assign o_instr_valid = r_valid;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state <= StReq;
         r_pc    <= RESET_PC;
         r_instr <= '0;
         r_valid <= 1'b0;
      end else if (i_redirect) begin
         // Any in-flight response belongs to the old path and must be dropped.
         r_pc    <= w_redirect_pc;
         r_valid <= 1'b0;
         case (r_state)
            StReq:   r_state <= w_accept      ? StDrain : StReq;
            StWait:  r_state <= i_imem_rvalid ? StReq   : StDrain;
            StValid: r_state <= StReq;
            StDrain: r_state <= i_imem_rvalid ? StReq   : StDrain;
            default: r_state <= StReq;
         endcase
      end else begin
         case (r_state)
            StReq: begin
               if (w_accept) r_state <= StWait;
            end
            StWait: begin
               if (i_imem_rvalid) begin
                  r_instr <= i_imem_rdata;
                  r_valid <= 1'b1;
                  r_state <= StValid;
               end
            end
            StValid: begin
               if (!i_stallF) begin
                  r_pc    <= w_pc_plus4;
                  r_valid <= 1'b0;
                  r_state <= StReq;
               end
            end
            StDrain: begin
               if (i_imem_rvalid) r_state <= StReq;
            end
            default: r_state <= StReq;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple memory model and a scoreboard of
// expected {pc, instr} pairs pushed on each accepted request.
module tb_fetch_unit;

   localparam int unsigned DW = 64;
   localparam int unsigned IW = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          stall;
   logic          redirect;
   logic [DW-1:0] redirect_pc;
   logic          imem_req;
   logic [DW-1:0] imem_addr;
   logic          imem_ready;
   logic          imem_rvalid;
   logic [IW-1:0] imem_rdata;
   logic [IW-1:0] instr;
   logic [DW-1:0] pc;
   logic [DW-1:0] pc_plus4;
   logic          instr_valid;

   fetch_unit #(
      .DATA_WIDTH  (DW),
      .INSTR_WIDTH (IW),
      .RESET_PC    (64'h1000)
   ) dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .i_stallF      (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_ready  (imem_ready),
      .i_imem_rvalid (imem_rvalid),
      .i_imem_rdata  (imem_rdata),
      .o_instr       (instr),
      .o_pc          (pc),
      .o_pc_plus4    (pc_plus4),
      .o_instr_valid (instr_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] pc;
      logic [IW-1:0] instr;
   } exp_t;

   exp_t          sb[$];
   int            errors = 0;
   int            checks = 0;
   int            mem_delay = 0;
   int            mem_cnt = 0;
   logic          mem_pend = 1'b0;
   logic [DW-1:0] mem_paddr = '0;
   int            resp_cnt = 0;
   logic          prev_valid = 1'b0;
   logic [IW-1:0] held_instr;

   function automatic logic [IW-1:0] mem_word(input logic [DW-1:0] a);
      if (a == 64'h1000) return 32'h0000_0013;
      return a[31:0] ^ 32'hC0DE_0003;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample the request before the edge, then drive memory and
   // compare any newly valid instruction against the scoreboard.
   task automatic tick();
      logic          acc;
      logic [DW-1:0] a;
      exp_t          e;
      #1;
      acc = imem_req && imem_ready;
      a   = imem_addr;
      if (!rstn) begin
         sb.delete();
         mem_pend = 1'b0;
      end else if (redirect) begin
         sb.delete();
      end else if (acc) begin
         sb.push_back('{pc: a, instr: mem_word(a)});
      end
      @(posedge clk);
      #1;
      redirect = 1'b0;
      if (acc && rstn) begin
         mem_pend  = 1'b1;
         mem_cnt   = mem_delay;
         mem_paddr = a;
      end
      imem_rvalid = 1'b0;
      if (rstn && mem_pend) begin
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_paddr);
            mem_pend    = 1'b0;
            resp_cnt++;
         end else begin
            mem_cnt--;
         end
      end
      if (instr_valid && !prev_valid) begin
         chk("sb_nonempty", DW'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_instr", DW'(instr), DW'(e.instr));
            chk("sb_pc_plus4", pc_plus4, e.pc + 64'd4);
         end
      end
      prev_valid = instr_valid;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!instr_valid && n < budget) begin
         tick();
         n++;
      end
      chk(tag, DW'(instr_valid), 64'd1);
   endtask

   initial begin
      int r0;
      rstn        = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;

      // Reset
      tick();
      tick();
      chk("rst_req_forced0", DW'(imem_req), 64'd0);
      chk("rst_valid", DW'(instr_valid), 64'd0);
      chk("rst_pc", pc, 64'h1000);
      chk("rst_instr", DW'(instr), 64'd0);
      rstn = 1'b1;
      #1;
      chk("first_req", DW'(imem_req), 64'd1);
      chk("first_addr", imem_addr, 64'h1000);

      // First fetch: ready=1, rvalid one cycle after accept
      wait_valid("first_valid", 10);
      chk("first_instr", DW'(instr), 64'h13);
      chk("first_pc4", pc_plus4, 64'h1004);

      // Stall in StValid holds everything
      stall      = 1'b1;
      held_instr = instr;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_valid", DW'(instr_valid), 64'd1);
         chk("stall_instr", DW'(instr), DW'(held_instr));
         chk("stall_pc", pc, 64'h1000);
         chk("stall_noreq", DW'(imem_req), 64'd0);
      end
      stall = 1'b0;
      tick();
      chk("release_valid", DW'(instr_valid), 64'd0);
      chk("release_req", DW'(imem_req), 64'd1);
      chk("release_addr", imem_addr, 64'h1004);
      wait_valid("second_valid", 10);
      tick();  // consume 0x1004; now requesting 0x1008

      // Redirect in StWait before rvalid -> drain, word discarded
      mem_delay = 3;
      tick();  // accept 0x1008
      redirect    = 1'b1;
      redirect_pc = 64'h2002;
      tick();
      chk("drain_pc", pc, 64'h2000);
      chk("drain_noreq", DW'(imem_req), 64'd0);
      for (int i = 0; i < 10 && !imem_req; i++) begin
         tick();
         chk("drain_valid_low", DW'(instr_valid), 64'd0);
      end
      chk("drain_req", DW'(imem_req), 64'd1);
      chk("drain_addr", imem_addr, 64'h2000);
      mem_delay = 0;
      wait_valid("after_drain_valid", 10);

      // Redirect coincident with stall in StValid
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 64'h3000;
      tick();
      stall = 1'b0;
      chk("redir_stall_valid", DW'(instr_valid), 64'd0);
      chk("redir_stall_req", DW'(imem_req), 64'd1);
      chk("redir_stall_addr", imem_addr, 64'h3000);

      // Backpressure with a redirect while the request waits
      imem_ready = 1'b0;
      r0 = resp_cnt;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            redirect    = 1'b1;
            redirect_pc = 64'h4000;
         end
         tick();
         chk("bp_req", DW'(imem_req), 64'd1);
         chk("bp_addr", imem_addr, (i >= 2) ? 64'h4000 : 64'h3000);
      end
      imem_ready = 1'b1;
      wait_valid("bp_valid", 10);
      chk("bp_one_resp", DW'(resp_cnt - r0), 64'd1);

      // Wrap from the top of the address space
      redirect    = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      wait_valid("wrap_valid", 10);
      chk("wrap_pc4", pc_plus4, 64'd0);
      tick();
      chk("wrap_pc", pc, 64'd0);

      // Reset in StWait
      mem_delay = 2;
      tick();  // accept at 0
      rstn = 1'b0;
      tick();
      chk("rst_wait_pc", pc, 64'h1000);
      chk("rst_wait_valid", DW'(instr_valid), 64'd0);
      chk("rst_wait_noreq", DW'(imem_req), 64'd0);
      rstn      = 1'b1;
      mem_delay = 0;
      #1;
      chk("rst_wait_req", DW'(imem_req), 64'd1);
      chk("rst_wait_addr", imem_addr, 64'h1000);
      wait_valid("rst_wait_refetch", 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
